// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and the memory handshake,
// and halts in TRAP on illegal opcodes or unanswered memory requests.
//
// state  | meaning
// -------+--------------------------------------------------------------
// FETCH  | request instruction word, load IR and pc+4 on mem_ready
// DECODE | classify opcode, latch class, trap on unknown opcode
// EXEC   | ALU operation; branches resolve here and return to FETCH
// MEM    | load/store data access, wait for mem_ready
// WB     | register-file write of ALU result or load data
// TRAP   | halted, all enables off, left only through rst_n
module riscv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       br_cond,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [2:0] C_R  = 3'd0;
    localparam logic [2:0] C_I  = 3'd1;
    localparam logic [2:0] C_LD = 3'd2;
    localparam logic [2:0] C_ST = 3'd3;
    localparam logic [2:0] C_BR = 3'd4;

    // Last unanswered cycle count before the timeout fires.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] state, state_nx;
    logic [2:0] cls, cls_dec;
    logic       legal;
    logic [7:0] wait_cnt;
    logic [1:0] cause_nx;
    logic       timed_out;

    assign state_dbg = state;
    assign timed_out = !mem_ready && (wait_cnt == TO_LAST);

    // Opcode classification, only consumed while in DECODE.
    always_comb begin
        cls_dec = C_R;
        legal   = 1'b1;
        case (opcode)
            7'b0110011: cls_dec = C_R;
            7'b0010011: cls_dec = C_I;
            7'b0000011: cls_dec = C_LD;
            7'b0100011: cls_dec = C_ST;
            7'b1100011: cls_dec = C_BR;
            default:    legal   = 1'b0;
        endcase
    end

    // Next-state logic and trap cause for the entering-TRAP transition.
    always_comb begin
        state_nx = state;
        cause_nx = 2'b00;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_nx = S_DECODE;
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = 2'b10;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_nx = S_EXEC;
                end else begin
                    state_nx = S_TRAP;
                    cause_nx = 2'b01;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_R, C_I:   state_nx = S_WB;
                    C_LD, C_ST: state_nx = S_MEM;
                    default:    state_nx = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_nx = (cls == C_LD) ? S_WB : S_FETCH;
                end else if (timed_out) begin
                    state_nx = S_TRAP;
                    cause_nx = 2'b10;
                end
            end
            S_WB:    state_nx = S_FETCH;
            S_TRAP:  state_nx = S_TRAP;
            default: state_nx = S_FETCH;
        endcase
    end

    // State, class latch, wait counter and sticky trap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            cls        <= C_R;
            wait_cnt   <= 8'd0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                cls <= cls_dec;
            end
            if (state_nx != state) begin
                wait_cnt <= 8'd0;
            end else if ((state == S_FETCH || state == S_MEM) && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state_nx == S_TRAP && state != S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= cause_nx;
            end
        end
    end

    // Output decode; gated by rst_n so everything is quiet while reset is held.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                S_EXEC: begin
                    case (cls)
                        C_I: alu_src_b = 1'b1;
                        C_LD, C_ST: begin
                            alu_op    = 2'b10;
                            alu_src_b = 1'b1;
                        end
                        C_BR: begin
                            alu_op = 2'b01;
                            pc_we  = br_cond;
                            pc_sel = br_cond;
                        end
                        default: alu_src_b = 1'b0;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    alu_op  = 2'b10;
                    mem_we  = (cls == C_ST);
                end
                S_WB: begin
                    reg_we = 1'b1;
                    wb_sel = (cls == C_LD);
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

endmodule
